// File: rtl/tx_slot_packer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tx_slot_packer_pkg
//  Description : Shared definitions for the transmit slot packer: slot tag
//                field layout, saturation limits, packer state encoding and
//                status bus field offsets (also used by the receive-side
//                status decoder).
//  Revision    : 1.0 - initial release
// ============================================================================
package tx_slot_packer_pkg;

    // Slot tag layout: bit0 = imag flag, bits[7:1] = channel index
    localparam int TAG_WIDTH    = 8;
    localparam int TAG_IMAG_BIT = 0;
    localparam int TAG_CHAN_LSB = 1;
    localparam int TAG_CHAN_W   = 7;

    // Status bus layout: {drop_cnt[15:0], seq_err_cnt[15:0], frame_cnt[31:0]}
    localparam int STAT_WIDTH     = 64;
    localparam int STAT_FRAME_LSB = 0;
    localparam int STAT_FRAME_W   = 32;
    localparam int STAT_SEQ_LSB   = 32;
    localparam int STAT_SEQ_W     = 16;
    localparam int STAT_DROP_LSB  = 48;
    localparam int STAT_DROP_W    = 16;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_HOLD = 2'd1,
        ST_HUNT = 2'd2
    } state_t;

    // Largest / smallest representable value of a signed w-bit sample
    function automatic logic signed [63:0] sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

    // Counters stick at all-ones rather than wrapping
    function automatic logic [15:0] inc_sat16(input logic [15:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction

    function automatic logic [31:0] inc_sat32(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tx_slot_packer_sat_shl.sv
`default_nettype none
// ============================================================================
//  Module      : sat_shl
//  Description : Signed arithmetic left shift by a variable amount with
//                symmetric saturation to the SAMP_WIDTH signed range.
//                Purely combinational.
//  Ports       : i_data  - signed input sample
//                i_shift - left shift amount
//                o_data  - shifted, saturated sample
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_shl
    import tx_slot_packer_pkg::*;
#(
    parameter int SAMP_WIDTH  = 16,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic signed [SAMP_WIDTH-1:0]  i_data,
    input  logic        [SHIFT_WIDTH-1:0] i_shift,
    output logic signed [SAMP_WIDTH-1:0]  o_data
);

    // 32 guard bits hold any shift up to 31 without losing the sign
    localparam int C_EXT = SAMP_WIDTH + 32;
    localparam logic signed [C_EXT-1:0] C_MAX = C_EXT'(sat_max(SAMP_WIDTH));
    localparam logic signed [C_EXT-1:0] C_MIN = C_EXT'(sat_min(SAMP_WIDTH));

    logic signed [C_EXT-1:0] w_ext;
    logic signed [C_EXT-1:0] w_shl;

    assign w_ext = {{32{i_data[SAMP_WIDTH-1]}}, i_data};
    assign w_shl = w_ext <<< i_shift;

    always_comb begin
        o_data = w_shl[SAMP_WIDTH-1:0];
        if (w_shl > C_MAX) begin
            o_data = C_MAX[SAMP_WIDTH-1:0];
        end else if (w_shl < C_MIN) begin
            o_data = C_MIN[SAMP_WIDTH-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/tx_slot_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tx_slot_packer
//  Description : Transmit frame assembler. Takes a TDM, slot-tagged IQ sample
//                stream, undoes the per-channel gain shift (left shift with
//                saturation) and packs NUM_CHANS complex samples into one wide
//                output frame. Checks slot ordering and resynchronises on
//                errors; frame / sequence-error / drop counters on status.
//  Ports       : aclk, areset         - clock, synchronous active-high reset
//                s_tdata/tuser/tvalid/tready - tagged sample input stream
//                cfg_shift            - per-channel left shift
//                m_tdata/tvalid/tready - packed frame output stream
//                status               - {drop, seq_err, frame} counters
//  Revision    : 1.0 - initial release
// ============================================================================
module tx_slot_packer
    import tx_slot_packer_pkg::*;
#(
    parameter int SAMP_WIDTH  = 16,
    parameter int NUM_CHANS   = 13,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic                              aclk,
    input  logic                              areset,
    input  logic [SAMP_WIDTH-1:0]             s_tdata,
    input  logic [7:0]                        s_tuser,
    input  logic                              s_tvalid,
    output logic                              s_tready,
    input  logic [SHIFT_WIDTH*NUM_CHANS-1:0]  cfg_shift,
    output logic [SAMP_WIDTH*NUM_CHANS*2-1:0] m_tdata,
    output logic                              m_tvalid,
    input  logic                              m_tready,
    output logic [63:0]                       status
);

    localparam int C_SLOTS = 2 * NUM_CHANS;
    localparam int C_FW    = SAMP_WIDTH * C_SLOTS;
    localparam logic [TAG_WIDTH-1:0] C_LAST_SLOT = TAG_WIDTH'(C_SLOTS - 1);

    state_t                           r_state;
    logic [TAG_WIDTH-1:0]             r_slot;
    logic [C_FW-1:0]                  r_buf;
    logic [SHIFT_WIDTH*NUM_CHANS-1:0] r_shift;
    logic [C_FW-1:0]                  r_mdata;
    logic                             r_mvalid;
    logic [31:0]                      r_frame_cnt;
    logic [15:0]                      r_seq_cnt;
    logic [15:0]                      r_drop_cnt;

    logic                             w_ready;
    logic                             w_out_free;
    logic                             w_match;
    logic                             w_tag_zero;
    logic [TAG_CHAN_W-1:0]            w_chan;
    logic [SHIFT_WIDTH-1:0]           w_shift;
    logic [SAMP_WIDTH-1:0]            w_sat;
    logic [C_FW-1:0]                  w_merged;

    assign w_ready    = (r_state != ST_HOLD);
    assign w_out_free = !r_mvalid || m_tready;
    assign w_match    = (s_tuser == r_slot);
    assign w_tag_zero = (s_tuser == '0);
    assign w_chan     = s_tuser[TAG_CHAN_LSB +: TAG_CHAN_W];

    // A tag-0 sample always starts a frame and the shifts are latched on that
    // same edge, so it must use cfg_shift directly; every later slot uses the
    // latched copy so a mid-frame reconfiguration cannot split a frame.
    always_comb begin
        w_shift = '0;
        if (w_tag_zero) begin
            w_shift = cfg_shift[SHIFT_WIDTH-1:0];
        end else begin
            for (int k = 0; k < NUM_CHANS; k++) begin
                if (w_chan == TAG_CHAN_W'(k)) begin
                    w_shift = r_shift[k*SHIFT_WIDTH +: SHIFT_WIDTH];
                end
            end
        end
    end

    sat_shl #(
        .SAMP_WIDTH  (SAMP_WIDTH),
        .SHIFT_WIDTH (SHIFT_WIDTH)
    ) u_sat_shl (
        .i_data  (s_tdata),
        .i_shift (w_shift),
        .o_data  (w_sat)
    );

    // Buffer with the last slot replaced by the sample arriving now, so a
    // completed frame goes straight to the output in one cycle.
    always_comb begin
        w_merged = r_buf;
        w_merged[(C_SLOTS-1)*SAMP_WIDTH +: SAMP_WIDTH] = w_sat;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state     <= ST_FILL;
            r_slot      <= '0;
            r_buf       <= '0;
            r_shift     <= '0;
            r_mdata     <= '0;
            r_mvalid    <= 1'b0;
            r_frame_cnt <= '0;
            r_seq_cnt   <= '0;
            r_drop_cnt  <= '0;
        end else begin
            // Output drains; a load below in the same cycle takes precedence
            if (r_mvalid && m_tready) begin
                r_mvalid <= 1'b0;
            end

            case (r_state)
                ST_FILL: begin
                    if (s_tvalid) begin
                        if (w_match) begin
                            if (r_slot == '0) begin
                                r_shift <= cfg_shift;
                            end
                            if (r_slot == C_LAST_SLOT) begin
                                if (w_out_free) begin
                                    r_mdata     <= w_merged;
                                    r_mvalid    <= 1'b1;
                                    r_frame_cnt <= inc_sat32(r_frame_cnt);
                                    r_slot      <= '0;
                                end else begin
                                    r_buf[(C_SLOTS-1)*SAMP_WIDTH +: SAMP_WIDTH] <= w_sat;
                                    r_state <= ST_HOLD;
                                end
                            end else begin
                                r_buf[int'(r_slot)*SAMP_WIDTH +: SAMP_WIDTH] <= w_sat;
                                r_slot <= r_slot + 1'b1;
                            end
                        end else begin
                            r_seq_cnt <= inc_sat16(r_seq_cnt);
                            if (r_slot != '0) begin
                                r_drop_cnt <= inc_sat16(r_drop_cnt);
                            end
                            if (w_tag_zero) begin
                                r_buf[SAMP_WIDTH-1:0] <= w_sat;
                                r_shift <= cfg_shift;
                                r_slot  <= TAG_WIDTH'(1);
                            end else begin
                                r_slot  <= '0;
                                r_state <= ST_HUNT;
                            end
                        end
                    end
                end

                ST_HOLD: begin
                    if (w_out_free) begin
                        r_mdata     <= r_buf;
                        r_mvalid    <= 1'b1;
                        r_frame_cnt <= inc_sat32(r_frame_cnt);
                        r_slot      <= '0;
                        r_state     <= ST_FILL;
                    end
                end

                ST_HUNT: begin
                    if (s_tvalid) begin
                        if (w_tag_zero) begin
                            r_buf[SAMP_WIDTH-1:0] <= w_sat;
                            r_shift <= cfg_shift;
                            r_slot  <= TAG_WIDTH'(1);
                            r_state <= ST_FILL;
                        end else begin
                            r_drop_cnt <= inc_sat16(r_drop_cnt);
                        end
                    end
                end

                default: begin
                    r_state <= ST_FILL;
                    r_slot  <= '0;
                end
            endcase
        end
    end

    assign s_tready = w_ready;
    assign m_tdata  = r_mdata;
    assign m_tvalid = r_mvalid;

    always_comb begin
        status = '0;
        status[STAT_FRAME_LSB +: STAT_FRAME_W] = r_frame_cnt;
        status[STAT_SEQ_LSB   +: STAT_SEQ_W]   = r_seq_cnt;
        status[STAT_DROP_LSB  +: STAT_DROP_W]  = r_drop_cnt;
    end

endmodule
`default_nettype wire

// File: tb/tb_tx_slot_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tx_slot_packer
//  Description : Directed self-checking bench for tx_slot_packer (N=13).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tx_slot_packer;

    localparam int W  = 16;
    localparam int N  = 13;
    localparam int SW = 5;
    localparam int S  = 2 * N;
    localparam int FW = W * S;

    logic           aclk;
    logic           areset;
    logic [W-1:0]   s_tdata;
    logic [7:0]     s_tuser;
    logic           s_tvalid;
    logic           s_tready;
    logic [SW*N-1:0] cfg_shift;
    logic [FW-1:0]  m_tdata;
    logic           m_tvalid;
    logic           m_tready;
    logic [63:0]    status;

    int n_checks;
    int n_errors;

    tx_slot_packer #(
        .SAMP_WIDTH  (W),
        .NUM_CHANS   (N),
        .SHIFT_WIDTH (SW)
    ) dut (
        .aclk      (aclk),
        .areset    (areset),
        .s_tdata   (s_tdata),
        .s_tuser   (s_tuser),
        .s_tvalid  (s_tvalid),
        .s_tready  (s_tready),
        .cfg_shift (cfg_shift),
        .m_tdata   (m_tdata),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .status    (status)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string name, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic send(input int tag, input logic [W-1:0] d);
        s_tvalid = 1'b1;
        s_tuser  = 8'(tag);
        s_tdata  = d;
        tick();
        s_tvalid = 1'b0;
    endtask

    task automatic send_range(input int lo, input int hi, input logic [W-1:0] base);
        for (int t = lo; t <= hi; t++) begin
            send(t, base + W'(t));
        end
    endtask

    function automatic logic [FW-1:0] mk_frame(input logic [W-1:0] base);
        logic [FW-1:0] f;
        for (int i = 0; i < S; i++) begin
            f[i*W +: W] = base + W'(i);
        end
        return f;
    endfunction

    function automatic logic [63:0] st(input int drop, input int seq, input int frm);
        return {16'(drop), 16'(seq), 32'(frm)};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [FW-1:0] exp_f;
        n_checks  = 0;
        n_errors  = 0;
        areset    = 1'b1;
        s_tdata   = '0;
        s_tuser   = '0;
        s_tvalid  = 1'b0;
        cfg_shift = '0;
        m_tready  = 1'b1;
        tick();
        tick();
        check("reset_mvalid", FW'(m_tvalid), FW'(1'b0));
        check("reset_mdata", m_tdata, '0);
        check("reset_status", FW'(status), FW'(64'd0));
        areset = 1'b0;
        tick();
        check("reset_tready", FW'(s_tready), FW'(1'b1));

        // Ordered stream, data = tag, no shift
        send_range(0, 24, 16'h0000);
        check("t1_no_early_valid", FW'(m_tvalid), FW'(1'b0));
        send(25, 16'h0019);
        check("t1_mvalid", FW'(m_tvalid), FW'(1'b1));
        check("t1_frame", m_tdata, mk_frame(16'h0000));
        check("t1_status", FW'(status), FW'(st(0, 0, 1)));
        tick();
        check("t1_drain", FW'(m_tvalid), FW'(1'b0));

        // Shift 4 on channel 3 (slots 6 and 7)
        cfg_shift = '0;
        cfg_shift[3*SW +: SW] = 5'd4;
        send_range(0, 5, 16'h0000);
        send(6, 16'h0100);
        send_range(7, 25, 16'h0000);
        exp_f = mk_frame(16'h0000);
        exp_f[6*W +: W] = 16'h1000;
        exp_f[7*W +: W] = 16'h0070;
        check("t3_shift_plain", m_tdata, exp_f);
        tick();

        send_range(0, 5, 16'h0000);
        send(6, 16'h0900);
        send_range(7, 25, 16'h0000);
        exp_f[6*W +: W] = 16'h7FFF;
        check("t3_sat_pos", m_tdata, exp_f);
        tick();

        // Shifts change after slot 0: the frame must keep the latched value
        send(0, 16'h0000);
        cfg_shift = '0;
        send_range(1, 5, 16'h0000);
        send(6, 16'hF700);
        send_range(7, 25, 16'h0000);
        exp_f[6*W +: W] = 16'h8000;
        check("t3_sat_neg_latched", m_tdata, exp_f);
        check("t3_status", FW'(status), FW'(st(0, 0, 4)));
        tick();

        // Backpressure across two frames
        m_tready = 1'b0;
        send_range(0, 25, 16'h0100);
        check("t4_a_valid", FW'(m_tvalid), FW'(1'b1));
        check("t4_a_frame", m_tdata, mk_frame(16'h0100));
        send_range(0, 25, 16'h0200);
        check("t4_hold_tready", FW'(s_tready), FW'(1'b0));
        check("t4_a_stable", m_tdata, mk_frame(16'h0100));
        check("t4_hold_status", FW'(status), FW'(st(0, 0, 5)));
        tick();
        check("t4_still_hold", FW'(s_tready), FW'(1'b0));
        m_tready = 1'b1;
        tick();
        check("t4_b_frame", m_tdata, mk_frame(16'h0200));
        check("t4_b_valid", FW'(m_tvalid), FW'(1'b1));
        check("t4_fill_tready", FW'(s_tready), FW'(1'b1));
        check("t4_b_status", FW'(status), FW'(st(0, 0, 6)));
        tick();
        check("t4_b_drain", FW'(m_tvalid), FW'(1'b0));

        // Out-of-order tag mid-frame -> HUNT
        send_range(0, 9, 16'h0300);
        send(14, 16'h030E);
        check("t5_err_status", FW'(status), FW'(st(1, 1, 6)));
        check("t5_hunt_tready", FW'(s_tready), FW'(1'b1));
        send(15, 16'h030F);
        send(16, 16'h0310);
        check("t5_hunt_drops", FW'(status), FW'(st(3, 1, 6)));
        check("t5_no_frame", FW'(m_tvalid), FW'(1'b0));
        send_range(0, 25, 16'h0300);
        check("t5_frame", m_tdata, mk_frame(16'h0300));
        check("t5_status", FW'(status), FW'(st(3, 1, 7)));
        tick();

        // Tag 0 mid-frame restarts without hunting
        send(0, 16'h04AA);
        send_range(1, 5, 16'h0400);
        send(0, 16'h0400);
        check("t6_restart_status", FW'(status), FW'(st(4, 2, 7)));
        send_range(1, 25, 16'h0400);
        check("t6_frame", m_tdata, mk_frame(16'h0400));
        check("t6_status", FW'(status), FW'(st(4, 2, 8)));
        tick();

        // Reset with a partial frame in flight
        send_range(0, 11, 16'h0600);
        areset = 1'b1;
        tick();
        check("t7_rst_mvalid", FW'(m_tvalid), FW'(1'b0));
        check("t7_rst_status", FW'(status), FW'(st(0, 0, 0)));
        check("t7_rst_mdata", m_tdata, '0);
        tick();
        areset = 1'b0;
        send_range(0, 25, 16'h0500);
        check("t7_frame", m_tdata, mk_frame(16'h0500));
        check("t7_mvalid", FW'(m_tvalid), FW'(1'b1));
        check("t7_status", FW'(status), FW'(st(0, 0, 1)));
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
